// File: rtl/mem_bus_responder.sv
// mem_bus_responder: memory-bus target fronting a 1-cycle sync RAM with wait states, plus a small MMIO page.
module mem_bus_responder #(
  parameter int          ADDR_BITS  = 14,
  parameter int          READ_WAIT  = 1,
  parameter int          WRITE_WAIT = 0,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic                 CoreClock,
  input  logic                 Reset,
  input  logic [31:0]          AddressBus,
  input  logic [31:0]          DataWriteBus,
  input  logic                 WriteAssert,
  output logic [31:0]          DataReadBus,
  output logic                 ReadOK,
  output logic                 WriteOK,
  output logic [ADDR_BITS-1:0] RamAddress,
  output logic [31:0]          RamWriteData,
  output logic                 RamWriteEnable,
  input  logic [31:0]          RamReadData,
  output logic [9:0]           LedReg,
  output logic [15:0]          HexReg,
  output logic                 BusFault
);
  localparam int RW = READ_WAIT < 1 ? 1 : READ_WAIT;
  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, WR_DONE, WR_HOLD} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rd_addr_q, rd_addr_d, last_q, last_d, data_q, data_d;
  logic [31:0] wa_q, wa_d, wd_q, wd_d, cycles_q, offs, mmio_rd;
  logic        valid_q, valid_d, fault_q, fault_d, is_ram, is_mmio, commit;
  logic [9:0]  led_q, led_d;
  logic [15:0] hex_q, hex_d;
  assign offs           = AddressBus - MMIO_BASE;
  assign is_ram         = (AddressBus >> ADDR_BITS) == 32'd0;
  assign is_mmio        = offs < 32'd3;
  assign mmio_rd        = offs == 32'd0 ? {22'd0, led_q} : offs == 32'd1 ? {16'd0, hex_q} : cycles_q;
  assign ReadOK         = valid_q & ~WriteAssert & (AddressBus == last_q);
  // outputs decoded from WR_DONE are masked by Reset so an interrupted write never reaches the RAM
  assign commit         = (state_q == WR_DONE) & WriteAssert & ~Reset;
  assign WriteOK        = commit;
  assign RamWriteEnable = commit & is_ram;
  assign RamAddress     = AddressBus[ADDR_BITS-1:0];
  assign RamWriteData   = DataWriteBus;
  assign DataReadBus    = data_q;
  assign LedReg         = led_q;
  assign HexReg         = hex_q;
  assign BusFault       = fault_q;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    last_d    = last_q;
    data_d    = data_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    wa_d      = wa_q;
    wd_d      = wd_q;
    led_d     = led_q;
    hex_d     = hex_q;
    unique case (state_q)
      IDLE: begin
        if (WriteAssert) begin
          state_d = WR_WAIT;
          cnt_d   = 8'(WRITE_WAIT);
        end else if (!ReadOK && is_ram) begin
          state_d   = RD_WAIT;
          cnt_d     = 8'(RW);
          rd_addr_d = AddressBus;
        end else if (!ReadOK) begin
          data_d  = is_mmio ? mmio_rd : 32'hDEAD_BEEF;
          last_d  = AddressBus;
          valid_d = 1'b1;
          fault_d = fault_q | ~is_mmio;
        end
      end
      RD_WAIT: begin
        if (WriteAssert) begin
          state_d = WR_WAIT;
          cnt_d   = 8'(WRITE_WAIT);
        end else if (AddressBus != rd_addr_q) begin
          state_d   = is_ram ? RD_WAIT : IDLE;
          cnt_d     = 8'(RW);
          rd_addr_d = AddressBus;
        end else if (cnt_q <= 8'd1) begin
          state_d = IDLE;
          data_d  = RamReadData;
          last_d  = AddressBus;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WR_WAIT: begin
        state_d = !WriteAssert ? IDLE : cnt_q == 8'd0 ? WR_DONE : WR_WAIT;
        cnt_d   = cnt_q == 8'd0 ? cnt_q : cnt_q - 8'd1;
      end
      WR_DONE: begin
        state_d = WriteAssert ? WR_HOLD : IDLE;
        if (WriteAssert) begin
          wa_d    = AddressBus;
          wd_d    = DataWriteBus;
          led_d   = offs == 32'd0 ? DataWriteBus[9:0] : led_q;
          hex_d   = offs == 32'd1 ? DataWriteBus[15:0] : hex_q;
          fault_d = fault_q | ~(is_ram | is_mmio);
          valid_d = valid_q & (AddressBus != last_q);
        end
      end
      WR_HOLD: begin
        if (!WriteAssert) begin
          state_d = IDLE;
        end else if (AddressBus != wa_q || DataWriteBus != wd_q) begin
          state_d = WR_WAIT;
          cnt_d   = 8'(WRITE_WAIT);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CoreClock) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      rd_addr_q <= 32'd0;
      last_q    <= 32'd0;
      data_q    <= 32'd0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      wa_q      <= 32'd0;
      wd_q      <= 32'd0;
      led_q     <= 10'd0;
      hex_q     <= 16'd0;
      cycles_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      last_q    <= last_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      led_q     <= led_d;
      hex_q     <= hex_d;
      cycles_q  <= cycles_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed vectors against two responder instances, each fronting a bench RAM model.
module tb_mem_bus_responder;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] a_addr = 32'd0, a_wd = 32'd0, a_rdb, a_ram_wd, a_ram_rd;
  logic        a_wa = 1'b0, a_rok, a_wok, a_we, a_fault;
  logic [13:0] a_ram_addr;
  logic [9:0]  a_led;
  logic [15:0] a_hex;
  logic [31:0] b_addr = 32'h0001_0000, b_wd = 32'd0, b_rdb, b_ram_wd, b_ram_rd;
  logic        b_wa = 1'b0, b_rok, b_wok, b_we, b_fault;
  logic [13:0] b_ram_addr;
  logic [9:0]  b_led;
  logic [15:0] b_hex;
  logic [31:0] mem_a [0:16383];
  logic [31:0] mem_b [0:16383];
  int          total = 0, bad = 0, we_a = 0, we_b = 0, wok_a = 0;
  logic        prev_a = 1'b0, prev_b = 1'b0, consec = 1'b0;
  logic [31:0] c1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        wa;
    int          cyc;
    logic        rok;
    logic [31:0] drb;
    int          we;
    logic [9:0]  led;
    logic [15:0] hex;
    logic        fault;
  } vec_t;
  vec_t vq[$];

  always #5 clk = ~clk;

  mem_bus_responder #(.ADDR_BITS(14), .READ_WAIT(1), .WRITE_WAIT(0)) dut_a (
    .CoreClock(clk), .Reset(rst), .AddressBus(a_addr), .DataWriteBus(a_wd), .WriteAssert(a_wa),
    .DataReadBus(a_rdb), .ReadOK(a_rok), .WriteOK(a_wok), .RamAddress(a_ram_addr),
    .RamWriteData(a_ram_wd), .RamWriteEnable(a_we), .RamReadData(a_ram_rd),
    .LedReg(a_led), .HexReg(a_hex), .BusFault(a_fault));

  mem_bus_responder #(.ADDR_BITS(14), .READ_WAIT(3), .WRITE_WAIT(2)) dut_b (
    .CoreClock(clk), .Reset(rst), .AddressBus(b_addr), .DataWriteBus(b_wd), .WriteAssert(b_wa),
    .DataReadBus(b_rdb), .ReadOK(b_rok), .WriteOK(b_wok), .RamAddress(b_ram_addr),
    .RamWriteData(b_ram_wd), .RamWriteEnable(b_we), .RamReadData(b_ram_rd),
    .LedReg(b_led), .HexReg(b_hex), .BusFault(b_fault));

  always @(posedge clk) begin
    if (a_we) mem_a[a_ram_addr] <= a_ram_wd;
    a_ram_rd <= mem_a[a_ram_addr];
    if (b_we) mem_b[b_ram_addr] <= b_ram_wd;
    b_ram_rd <= mem_b[b_ram_addr];
    if (a_we) we_a <= we_a + 1;
    if (b_we) we_b <= we_b + 1;
    if (a_wok) wok_a <= wok_a + 1;
    if ((a_wok && prev_a) || (b_wok && prev_b)) consec <= 1'b1;
    prev_a <= a_wok;
    prev_b <= b_wok;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [31:0] addr, input logic [31:0] wd, input logic wa, input int cyc,
                              input logic rok, input logic [31:0] drb, input int we,
                              input logic [9:0] led, input logic [15:0] hex, input logic fault);
    vec_t v;
    v.addr = addr; v.wd = wd; v.wa = wa; v.cyc = cyc; v.rok = rok; v.drb = drb;
    v.we = we; v.led = led; v.hex = hex; v.fault = fault;
    vq.push_back(v);
  endfunction

  task automatic b_write(input logic [31:0] addr, input logic [31:0] wd);
    b_addr = addr;
    b_wd = wd;
    b_wa = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    add(32'h5,         32'h1234_5678, 1, 3, 0, 32'h0,         1, 10'h0,   16'h0,    0);
    add(32'h3FFF,      32'hA5A5_0001, 1, 3, 0, 32'h0,         2, 10'h0,   16'h0,    0);
    add(32'h5,         32'h0,         0, 1, 0, 32'h0,         2, 10'h0,   16'h0,    0);
    add(32'h5,         32'h0,         0, 1, 0, 32'h0,         2, 10'h0,   16'h0,    0);
    add(32'h5,         32'h0,         0, 1, 1, 32'h1234_5678, 2, 10'h0,   16'h0,    0);
    add(32'h7,         32'hCAFE,      1, 5, 0, 32'h1234_5678, 3, 10'h0,   16'h0,    0);
    add(32'h7,         32'h0,         0, 1, 0, 32'h1234_5678, 3, 10'h0,   16'h0,    0);
    add(32'h7,         32'h0,         0, 2, 1, 32'hCAFE,      3, 10'h0,   16'h0,    0);
    add(32'h7,         32'hBEEF,      1, 4, 0, 32'hCAFE,      4, 10'h0,   16'h0,    0);
    add(32'h7,         32'h0,         0, 1, 0, 32'hCAFE,      4, 10'h0,   16'h0,    0);
    add(32'h7,         32'h0,         0, 2, 1, 32'hBEEF,      4, 10'h0,   16'h0,    0);
    add(32'hFFFF_FF00, 32'h3FF,       1, 3, 0, 32'hBEEF,      4, 10'h3FF, 16'h0,    0);
    add(32'hFFFF_FF01, 32'hABCD,      1, 3, 0, 32'hBEEF,      4, 10'h3FF, 16'hABCD, 0);
    add(32'hFFFF_FF00, 32'h0,         0, 2, 1, 32'h3FF,       4, 10'h3FF, 16'hABCD, 0);
    add(32'hFFFF_FF01, 32'h0,         0, 1, 1, 32'hABCD,      4, 10'h3FF, 16'hABCD, 0);
    add(32'h0001_0000, 32'h0,         0, 1, 1, 32'hDEAD_BEEF, 4, 10'h3FF, 16'hABCD, 1);
    add(32'h3FFF,      32'h0,         0, 2, 1, 32'hA5A5_0001, 4, 10'h3FF, 16'hABCD, 1);
    add(32'h5,         32'h0,         0, 2, 1, 32'h1234_5678, 4, 10'h3FF, 16'hABCD, 1);
    add(32'h0002_0000, 32'h1111,      1, 3, 0, 32'h1234_5678, 4, 10'h3FF, 16'hABCD, 1);
    add(32'h5,         32'h0,         0, 1, 1, 32'h1234_5678, 4, 10'h3FF, 16'hABCD, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rok", {31'd0, a_rok}, 32'd0);
    chk("reset_drb", a_rdb, 32'd0);
    chk("reset_wok", {31'd0, a_wok}, 32'd0);
    chk("reset_we", {31'd0, a_we}, 32'd0);
    chk("reset_led_hex", {6'd0, a_led, a_hex}, 32'd0);
    chk("reset_fault", {31'd0, a_fault}, 32'd0);
    rst = 1'b0;
    foreach (vq[i]) begin
      a_addr = vq[i].addr;
      a_wd = vq[i].wd;
      a_wa = vq[i].wa;
      repeat (vq[i].cyc) @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_rok", i), {31'd0, a_rok}, {31'd0, vq[i].rok});
      chk($sformatf("v%0d_drb", i), a_rdb, vq[i].drb);
      chk($sformatf("v%0d_we", i), we_a, vq[i].we);
      chk($sformatf("v%0d_led", i), {22'd0, a_led}, {22'd0, vq[i].led});
      chk($sformatf("v%0d_hex", i), {16'd0, a_hex}, {16'd0, vq[i].hex});
      chk($sformatf("v%0d_fault", i), {31'd0, a_fault}, {31'd0, vq[i].fault});
    end
    chk("wok_count", wok_a, 7);
    a_addr = 32'h0001_2345;
    a_wd = 32'h0BAD_F00D;
    #1;
    chk("ram_addr", {18'd0, a_ram_addr}, 32'h2345);
    chk("ram_wdata", a_ram_wd, 32'h0BAD_F00D);
    a_addr = 32'hFFFF_FF02;
    @(posedge clk);
    @(negedge clk);
    chk("cyc_rok", {31'd0, a_rok}, 32'd1);
    c1 = a_rdb;
    a_addr = 32'hFFFF_FF00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_addr = 32'hFFFF_FF02;
    @(posedge clk);
    @(negedge clk);
    chk("cyc_delta", a_rdb - c1, 32'd4);
    b_write(32'h5, 32'h5555_5555);
    b_write(32'h6, 32'h6666_6666);
    b_write(32'h9, 32'h0000_0011);
    b_addr = 32'h0001_0000;
    b_wa = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("b_idle_drb", b_rdb, 32'hDEAD_BEEF);
    b_addr = 32'h5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("b_rd_early", {31'd0, b_rok}, 32'd0);
    b_addr = 32'h6;
    for (int k = 3; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b_abort_rok_e%0d", k), {31'd0, b_rok}, 32'd0);
      chk($sformatf("b_abort_drb_e%0d", k), b_rdb, 32'hDEAD_BEEF);
    end
    @(posedge clk);
    @(negedge clk);
    chk("b_restart_rok", {31'd0, b_rok}, 32'd1);
    chk("b_restart_drb", b_rdb, 32'h6666_6666);
    chk("b_we_count", we_b, 3);
    b_addr = 32'h9;
    b_wd = 32'h0000_0099;
    b_wa = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    b_wa = 1'b0;
    chk("rst_a_fault", {31'd0, a_fault}, 32'd0);
    chk("rst_a_led", {22'd0, a_led}, 32'd0);
    chk("rst_a_rok", {31'd0, a_rok}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_no_commit", we_b, 3);
    chk("rst_mem9", mem_b[9], 32'h0000_0011);
    chk("wok_gap", {31'd0, consec}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
